// File: rtl/axis_shift_pkg.sv
// ============================================================================
// Module      : axis_shift_pkg
// Description : Shared state encoding, widths and helper functions for the
//               AXI4-Stream byte shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_shift_pkg;

    localparam int c_BYTE_W    = 8;
    localparam int c_MAX_LANES = 64;
    localparam int c_CNT_W     = 7;

    typedef enum logic [1:0] {
        ST_SOP   = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic int lane_count(input int bus_width);
        return bus_width / c_BYTE_W;
    endfunction

    function automatic logic [c_CNT_W-1:0] keep_popcount(input logic [c_MAX_LANES-1:0] keep);
        logic [c_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_LANES; i++) begin
            cnt = cnt + c_CNT_W'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic [c_CNT_W-1:0] clamp_shift(input logic [c_CNT_W-1:0] req,
                                                       input logic [c_CNT_W-1:0] max_s);
        return (req > max_s) ? max_s : req;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_lane_shift.sv
// ============================================================================
// Module      : axis_lane_shift
// Description : Combinational barrel shift of {data, keep, strb} toward higher
//               lanes, merging the previous carry and producing the next one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_lane_shift
    import axis_shift_pkg::*;
#(
    parameter int KEEP_WIDTH = 64,
    parameter int SHIFT_W    = 6
) (
    input  logic [SHIFT_W-1:0]             shift,
    input  logic [KEEP_WIDTH*c_BYTE_W-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0]          in_keep,
    input  logic [KEEP_WIDTH-1:0]          in_strb,
    input  logic [KEEP_WIDTH*c_BYTE_W-1:0] carry_in_data,
    input  logic [KEEP_WIDTH-1:0]          carry_in_keep,
    input  logic [KEEP_WIDTH-1:0]          carry_in_strb,
    output logic [KEEP_WIDTH*c_BYTE_W-1:0] out_data,
    output logic [KEEP_WIDTH-1:0]          out_keep,
    output logic [KEEP_WIDTH-1:0]          out_strb,
    output logic [KEEP_WIDTH*c_BYTE_W-1:0] carry_out_data,
    output logic [KEEP_WIDTH-1:0]          carry_out_keep,
    output logic [KEEP_WIDTH-1:0]          carry_out_strb
);

    localparam int c_DATA_W = KEEP_WIDTH * c_BYTE_W;

    logic [c_DATA_W-1:0]     w_data_clean;
    logic [2*c_DATA_W-1:0]   w_data_ext;
    logic [2*KEEP_WIDTH-1:0] w_keep_ext;
    logic [2*KEEP_WIDTH-1:0] w_strb_ext;

    // Null lanes carry zero data so both the output and the carry stay clean.
    generate
        for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane_mask
            assign w_data_clean[i*c_BYTE_W +: c_BYTE_W] =
                in_keep[i] ? in_data[i*c_BYTE_W +: c_BYTE_W] : {c_BYTE_W{1'b0}};
        end
    endgenerate

    // The upper half of each widened vector is the spill-over, already
    // aligned to lane 0 for merging into the next beat.
    assign w_data_ext = {{c_DATA_W{1'b0}}, w_data_clean} << {shift, 3'b000};
    assign w_keep_ext = {{KEEP_WIDTH{1'b0}}, in_keep} << shift;
    assign w_strb_ext = {{KEEP_WIDTH{1'b0}}, (in_strb & in_keep)} << shift;

    assign out_data = w_data_ext[c_DATA_W-1:0] | carry_in_data;
    assign out_keep = w_keep_ext[KEEP_WIDTH-1:0] | carry_in_keep;
    assign out_strb = w_strb_ext[KEEP_WIDTH-1:0] | carry_in_strb;

    assign carry_out_data = w_data_ext[2*c_DATA_W-1:c_DATA_W];
    assign carry_out_keep = w_keep_ext[2*KEEP_WIDTH-1:KEEP_WIDTH];
    assign carry_out_strb = w_strb_ext[2*KEEP_WIDTH-1:KEEP_WIDTH];

endmodule

`default_nettype wire

// File: rtl/axis_byte_shift.sv
// ============================================================================
// Module      : axis_byte_shift
// Description : AXI4-Stream byte shifter with per-packet runtime shift, carry
//               between beats, trailing flush beat and registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_byte_shift
    import axis_shift_pkg::*;
#(
    parameter int BUS_WIDTH       = 512,
    parameter int KEEP_WIDTH      = BUS_WIDTH / 8,
    parameter int MAX_SHIFT_BYTES = 63,
    parameter int SHIFT_W         = $clog2(MAX_SHIFT_BYTES + 1)
) (
    input  logic                  aclk,
    input  logic                  ARESET,
    input  logic [SHIFT_W-1:0]    shift_bytes,
    input  logic [BUS_WIDTH-1:0]  in_tdata,
    input  logic [KEEP_WIDTH-1:0] in_tkeep,
    input  logic [KEEP_WIDTH-1:0] in_tstrb,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    output logic [BUS_WIDTH-1:0]  out_tdata,
    output logic [KEEP_WIDTH-1:0] out_tkeep,
    output logic [KEEP_WIDTH-1:0] out_tstrb,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready
);

    state_t                  r_state;
    logic [SHIFT_W-1:0]      r_shift;
    logic [BUS_WIDTH-1:0]    r_carry_data;
    logic [KEEP_WIDTH-1:0]   r_carry_keep;
    logic [KEEP_WIDTH-1:0]   r_carry_strb;
    logic [BUS_WIDTH-1:0]    r_out_data;
    logic [KEEP_WIDTH-1:0]   r_out_keep;
    logic [KEEP_WIDTH-1:0]   r_out_strb;
    logic                    r_out_valid;
    logic                    r_out_last;

    logic                    w_first;
    logic [c_CNT_W-1:0]      w_shift_req;
    logic [SHIFT_W-1:0]      w_shift;
    logic [BUS_WIDTH-1:0]    w_cin_data;
    logic [KEEP_WIDTH-1:0]   w_cin_keep;
    logic [KEEP_WIDTH-1:0]   w_cin_strb;
    logic [BUS_WIDTH-1:0]    w_sh_data;
    logic [KEEP_WIDTH-1:0]   w_sh_keep;
    logic [KEEP_WIDTH-1:0]   w_sh_strb;
    logic [BUS_WIDTH-1:0]    w_cy_data;
    logic [KEEP_WIDTH-1:0]   w_cy_keep;
    logic [KEEP_WIDTH-1:0]   w_cy_strb;
    logic                    w_out_free;
    logic                    w_in_fire;
    logic [c_CNT_W:0]        w_fill;
    logic                    w_fits;

    assign w_first     = (r_state == ST_SOP);
    assign w_shift_req = clamp_shift(c_CNT_W'(shift_bytes), c_CNT_W'(MAX_SHIFT_BYTES));
    assign w_shift     = w_first ? SHIFT_W'(w_shift_req) : r_shift;

    // A new packet never inherits spill-over from the previous one.
    assign w_cin_data = w_first ? '0 : r_carry_data;
    assign w_cin_keep = w_first ? '0 : r_carry_keep;
    assign w_cin_strb = w_first ? '0 : r_carry_strb;

    assign w_out_free = !r_out_valid || out_tready;
    assign in_tready  = !ARESET && (r_state != ST_FLUSH) && w_out_free;
    assign w_in_fire  = in_tvalid && in_tready;

    assign w_fill = {1'b0, keep_popcount(c_MAX_LANES'(in_tkeep))} + {1'b0, c_CNT_W'(w_shift)};
    assign w_fits = (w_fill <= (c_CNT_W+1)'(KEEP_WIDTH));

    axis_lane_shift #(
        .KEEP_WIDTH (KEEP_WIDTH),
        .SHIFT_W    (SHIFT_W)
    ) u_lane_shift (
        .shift          (w_shift),
        .in_data        (in_tdata),
        .in_keep        (in_tkeep),
        .in_strb        (in_tstrb),
        .carry_in_data  (w_cin_data),
        .carry_in_keep  (w_cin_keep),
        .carry_in_strb  (w_cin_strb),
        .out_data       (w_sh_data),
        .out_keep       (w_sh_keep),
        .out_strb       (w_sh_strb),
        .carry_out_data (w_cy_data),
        .carry_out_keep (w_cy_keep),
        .carry_out_strb (w_cy_strb)
    );

    always_ff @(posedge aclk) begin
        if (ARESET) begin
            r_state      <= ST_SOP;
            r_shift      <= '0;
            r_carry_data <= '0;
            r_carry_keep <= '0;
            r_carry_strb <= '0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_strb   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            if (r_out_valid && out_tready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_SOP, ST_BODY: begin
                    if (w_in_fire) begin
                        r_out_data   <= w_sh_data;
                        r_out_keep   <= w_sh_keep;
                        r_out_strb   <= w_sh_strb;
                        r_out_valid  <= 1'b1;
                        r_carry_data <= w_cy_data;
                        r_carry_keep <= w_cy_keep;
                        r_carry_strb <= w_cy_strb;
                        r_shift      <= w_shift;
                        if (in_tlast && w_fits) begin
                            r_out_last <= 1'b1;
                            r_state    <= ST_SOP;
                        end else if (in_tlast) begin
                            r_out_last <= 1'b0;
                            r_state    <= ST_FLUSH;
                        end else begin
                            r_out_last <= 1'b0;
                            r_state    <= ST_BODY;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Spill-over keep is already exactly the tail lanes.
                    if (w_out_free) begin
                        r_out_data   <= r_carry_data;
                        r_out_keep   <= r_carry_keep;
                        r_out_strb   <= r_carry_strb;
                        r_out_valid  <= 1'b1;
                        r_out_last   <= 1'b1;
                        r_carry_data <= '0;
                        r_carry_keep <= '0;
                        r_carry_strb <= '0;
                        r_state      <= ST_SOP;
                    end
                end
                default: begin
                    r_state <= ST_SOP;
                end
            endcase
        end
    end

    assign out_tdata  = r_out_data;
    assign out_tkeep  = r_out_keep;
    assign out_tstrb  = r_out_strb;
    assign out_tvalid = r_out_valid;
    assign out_tlast  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_axis_byte_shift.sv
// ============================================================================
// Module      : tb_axis_byte_shift
// Description : Scoreboard bench for axis_byte_shift on an 8-lane bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_byte_shift;

    localparam int BW   = 64;
    localparam int KW   = 8;
    localparam int MAXS = 7;
    localparam int SW   = 4;

    logic          aclk = 1'b0;
    logic          ARESET = 1'b1;
    logic [SW-1:0] shift_bytes = '0;
    logic [BW-1:0] in_tdata = '0;
    logic [KW-1:0] in_tkeep = '0;
    logic [KW-1:0] in_tstrb = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic          in_tready;
    logic [BW-1:0] out_tdata;
    logic [KW-1:0] out_tkeep;
    logic [KW-1:0] out_tstrb;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready = 1'b1;

    axis_byte_shift #(
        .BUS_WIDTH       (BW),
        .KEEP_WIDTH      (KW),
        .MAX_SHIFT_BYTES (MAXS),
        .SHIFT_W         (SW)
    ) dut (
        .aclk        (aclk),
        .ARESET      (ARESET),
        .shift_bytes (shift_bytes),
        .in_tdata    (in_tdata),
        .in_tkeep    (in_tkeep),
        .in_tstrb    (in_tstrb),
        .in_tvalid   (in_tvalid),
        .in_tlast    (in_tlast),
        .in_tready   (in_tready),
        .out_tdata   (out_tdata),
        .out_tkeep   (out_tkeep),
        .out_tstrb   (out_tstrb),
        .out_tvalid  (out_tvalid),
        .out_tlast   (out_tlast),
        .out_tready  (out_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [KW-1:0] keep;
        logic [KW-1:0] strb;
        logic          last;
    } beat_t;

    beat_t        exp_q[$];
    byte unsigned pd[$];
    bit           ps[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    bit           sb_en    = 1'b1;
    bit           rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Output-side backpressure, changed only just after the active edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a transfer seen at the falling edge completes at the next rising edge.
    initial begin : monitor
        beat_t held;
        beat_t got;
        beat_t e;
        bit    holding;
        holding = 1'b0;
        forever begin
            @(negedge aclk);
            if (!sb_en || ARESET) begin
                holding = 1'b0;
            end else begin
                got = {out_tdata, out_tkeep, out_tstrb, out_tlast};
                if (holding) chk("hold_stable", 128'({out_tvalid, got}), 128'({1'b1, held}));
                holding = 1'b0;
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got %h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", 128'(got), 128'(e));
                    end
                end else if (out_tvalid) begin
                    held    = got;
                    holding = 1'b1;
                end
            end
        end
    end

    task automatic fill_seq(input int start, input int n);
        pd.delete(); ps.delete();
        for (int i = 0; i < n; i++) begin
            pd.push_back(8'(start + i));
            ps.push_back(1'b1);
        end
    endtask

    task automatic fill_rand(input int n);
        pd.delete(); ps.delete();
        for (int i = 0; i < n; i++) begin
            pd.push_back(8'($urandom));
            ps.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    // Reference: prepend S null bytes to the payload and cut into KW-lane beats.
    task automatic send_packet(input int s_first, input int s_later, output int stalls);
        int    n, s, nb_out, nb_in, j, guard;
        bit    done;
        beat_t e;
        n      = pd.size();
        s      = (s_first > MAXS) ? MAXS : s_first;
        nb_out = (s + n + KW - 1) / KW;
        nb_in  = (n + KW - 1) / KW;
        for (int b = 0; b < nb_out; b++) begin
            e = '0;
            for (int l = 0; l < KW; l++) begin
                j = b * KW + l - s;
                if (j >= 0 && j < n) begin
                    e.data[l*8 +: 8] = pd[j];
                    e.keep[l]        = 1'b1;
                    e.strb[l]        = ps[j];
                end
            end
            e.last = (b == nb_out - 1);
            exp_q.push_back(e);
        end
        stalls = 0;
        for (int b = 0; b < nb_in; b++) begin
            in_tvalid   = 1'b1;
            in_tlast    = (b == nb_in - 1);
            shift_bytes = (b == 0) ? SW'(s_first) : SW'(s_later);
            for (int l = 0; l < KW; l++) begin
                j = b * KW + l;
                if (j < n) begin
                    in_tdata[l*8 +: 8] = pd[j];
                    in_tkeep[l]        = 1'b1;
                    in_tstrb[l]        = ps[j];
                end else begin
                    in_tdata[l*8 +: 8] = 8'($urandom);
                    in_tkeep[l]        = 1'b0;
                    in_tstrb[l]        = 1'b0;
                end
            end
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge aclk);
                done = in_tready;
                @(posedge aclk);
                #1;
                if (!done) begin
                    stalls++;
                    guard++;
                    if (guard > 200) begin
                        n_checks++;
                        $display("FAIL in_tready_timeout: got 0 expected 1 within 200 cycles");
                        $display("%0d/%0d checks passed", n_pass, n_checks);
                        $fatal(1, "input stuck");
                    end
                end
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic drain;
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 1000) begin
            @(posedge aclk);
            g++;
        end
        chk("drain_pending", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int st;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_outputs", 128'({out_tvalid, out_tlast, out_tdata, out_tkeep, out_tstrb}), 128'(0));
        chk("reset_in_tready", 128'(in_tready), 128'(0));
        @(posedge aclk);
        #1;
        ARESET = 1'b0;
        @(posedge aclk);
        #1;

        // Pass-through with no shift.
        fill_seq(8'h00, 24);
        send_packet(0, 0, st);
        chk("s0_no_stall", 128'(st), 128'(0));
        drain();

        // Tail overflow produces a flush beat; input is held off meanwhile.
        fill_seq(8'h00, 16);
        send_packet(2, 2, st);
        @(negedge aclk);
        chk("flush_in_tready", 128'(in_tready), 128'(0));
        @(posedge aclk);
        #1;
        drain();

        // Single short beat that still fits.
        fill_seq(8'hA0, 5);
        send_packet(3, 3, st);
        drain();

        // Random backpressure with a fixed shift of 2.
        rdy_rand = 1'b1;
        for (int p = 0; p < 6; p++) begin
            fill_rand($urandom_range(1, 20));
            send_packet(2, 2, st);
        end
        drain();

        // Shift changes mid-packet are ignored; oversize requests clamp.
        fill_rand(12);
        send_packet(2, 5, st);
        fill_rand(10);
        send_packet(5, 2, st);
        fill_rand(9);
        send_packet(15, 15, st);
        for (int p = 0; p < 8; p++) begin
            fill_rand($urandom_range(1, 24));
            send_packet($urandom_range(0, 15), $urandom_range(0, 15), st);
        end
        drain();
        rdy_rand = 1'b0;
        @(posedge aclk);
        #1;

        // Reset in the middle of a packet.
        sb_en       = 1'b0;
        shift_bytes = SW'(4);
        in_tvalid   = 1'b1;
        in_tlast    = 1'b0;
        in_tkeep    = 8'hFF;
        in_tstrb    = 8'hFF;
        in_tdata    = 64'h1716151413121110;
        @(negedge aclk);
        chk("mid_beat1_ready", 128'(in_tready), 128'(1));
        @(posedge aclk);
        #1;
        in_tdata = 64'h1F1E1D1C1B1A1918;
        ARESET   = 1'b1;
        @(negedge aclk);
        chk("mid_reset_in_tready", 128'(in_tready), 128'(0));
        @(posedge aclk);
        #1;
        ARESET    = 1'b0;
        in_tvalid = 1'b0;
        @(negedge aclk);
        chk("mid_reset_out_tvalid", 128'(out_tvalid), 128'(0));
        @(posedge aclk);
        #1;
        exp_q.delete();
        sb_en = 1'b1;
        fill_seq(8'hC0, 4);
        send_packet(4, 4, st);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
